alu_serial_core: RTL

//  Bit-serial ALU stage built on the team's gate primitives (AND2, KATIO_OR2, NAND2, EXOR2, NOT1).

---
 rtl/alu_serial_core_pkg.sv | 21 ++
 rtl/alu_serial_core_slice.sv | 88 ++++++++
 rtl/alu_serial_core.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_serial_core_pkg.sv
// Shared op-codes, FSM state encodings and small helpers for the bit-serial ALU.
package alu_serial_core_pkg;

    localparam logic [2:0] ALU_OP_AND   = 3'b000;
    localparam logic [2:0] ALU_OP_OR    = 3'b001;
    localparam logic [2:0] ALU_OP_NAND  = 3'b010;
    localparam logic [2:0] ALU_OP_XOR   = 3'b011;
    localparam logic [2:0] ALU_OP_NOTA  = 3'b100;
    localparam logic [2:0] ALU_OP_ADD   = 3'b101;
    localparam logic [2:0] ALU_OP_SUB   = 3'b110;
    localparam logic [2:0] ALU_OP_PASSB = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_core_slice.sv
// Gate primitives and the 1-bit combinational ALU slice built from them.
module AND2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module KATIO_OR2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module NAND2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module EXOR2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module NOT1 (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module alu_bit_slice
    import alu_serial_core_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);
    logic w_and;
    logic w_or;
    logic w_nand;
    logic w_axb;
    logic w_na;
    logic w_sum;
    logic w_cx;
    logic w_r;

    AND2      u_and  (.a(a),     .b(b),     .y(w_and));
    KATIO_OR2 u_or   (.a(a),     .b(b),     .y(w_or));
    NAND2     u_nand (.a(a),     .b(b),     .y(w_nand));
    EXOR2     u_xor  (.a(a),     .b(b),     .y(w_axb));
    NOT1      u_not  (.a(a),                .y(w_na));
    // Full adder: sum = a^b^cin, cout = ab | cin(a^b); SUB arrives with b pre-inverted.
    EXOR2     u_sum  (.a(w_axb), .b(cin),   .y(w_sum));
    AND2      u_cx   (.a(cin),   .b(w_axb), .y(w_cx));
    KATIO_OR2 u_co   (.a(w_and), .b(w_cx),  .y(cout));

    // Result bit select by op-code.
    always_comb begin
        w_r = 1'b0;
        case (op)
            ALU_OP_AND:   w_r = w_and;
            ALU_OP_OR:    w_r = w_or;
            ALU_OP_NAND:  w_r = w_nand;
            ALU_OP_XOR:   w_r = w_axb;
            ALU_OP_NOTA:  w_r = w_na;
            ALU_OP_ADD:   w_r = w_sum;
            ALU_OP_SUB:   w_r = w_sum;
            ALU_OP_PASSB: w_r = b;
            default:      w_r = 1'b0;
        endcase
    end

    assign r = w_r;

endmodule

// File: rtl/alu_serial_core.sv
// Bit-serial ALU: one bit per clock LSB first, valid/ready on both sides.
// Optional flag outputs res_zero/res_carry are enabled by defining ALU_SERIAL_FLAGS_EN.
module alu_serial_core
    import alu_serial_core_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             res_zero,
    output logic             res_carry
`endif
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
`ifdef ALU_SERIAL_FLAGS_EN
    logic             r_res_zero;
    logic             r_res_carry;
`endif

    logic w_r;
    logic w_cout;
    logic w_accept;

    assign w_accept = in_valid && r_in_ready;

    alu_bit_slice u_slice (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .op   (r_op),
        .r    (w_r),
        .cout (w_cout)
    );

    // FSM, operand/result shifters, bit counter and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= 3'b000;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_acc       <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= {WIDTH{1'b0}};
`ifdef ALU_SERIAL_FLAGS_EN
            r_res_zero  <= 1'b0;
            r_res_carry <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= in_op;
                        r_a        <= in_a;
                        r_b        <= (in_op == ALU_OP_SUB) ? ~in_b : in_b;
                        r_carry    <= (in_op == ALU_OP_SUB);
                        r_acc      <= {WIDTH{1'b0}};
                        r_cnt      <= {CW{1'b0}};
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc <= {w_r, r_acc[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    if (is_arith(r_op)) begin
                        r_carry <= w_cout;
                    end
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the finished result; later cycles wait for the consumer.
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= r_acc;
`ifdef ALU_SERIAL_FLAGS_EN
                        r_res_zero  <= (r_acc == {WIDTH{1'b0}});
                        r_res_carry <= is_arith(r_op) ? r_carry : 1'b0;
`endif
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
`ifdef ALU_SERIAL_FLAGS_EN
    assign res_zero  = r_res_zero;
    assign res_carry = r_res_carry;
`endif

endmodule
